// File: rtl/key_event_gen.sv
// Push-button front end: synchronizes, debounces and edge-detects the DE2 KEY
// pins and emits single-cycle command pulses, with auto-repeat on masked keys.
module key_event_gen #(
  parameter int              NKEY             = 4,
  parameter int              DEBOUNCE_CYC     = 20000,
  parameter int              REPEAT_DELAY_CYC = 600000,
  parameter int              REPEAT_RATE_CYC  = 150000,
  parameter logic [NKEY-1:0] REPEAT_MASK      = 4'b0011
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NKEY-1:0] i_key_n,
  output logic [NKEY-1:0] o_press,
  output logic [NKEY-1:0] o_held
);

  localparam int MAX_DR  = (DEBOUNCE_CYC > REPEAT_DELAY_CYC) ? DEBOUNCE_CYC : REPEAT_DELAY_CYC;
  localparam int MAX_CYC = (MAX_DR > REPEAT_RATE_CYC) ? MAX_DR : REPEAT_RATE_CYC;
  localparam int CW      = $clog2(MAX_CYC);

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYC - 1);
  localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY_CYC - 1);
  localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEB_PRESS,
    ST_HELD,
    ST_REPEAT,
    ST_DEB_RELEASE
  } state_t;

  logic [NKEY-1:0] sync1_q;
  logic [NKEY-1:0] sync2_q;

  // Synchronizer resets to "released" so a key held through reset is re-debounced.
  always_ff @(posedge i_clk) begin
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of statement order.
    if (!i_rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= i_key_n;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NKEY; g++) begin : g_key
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;
    logic          s;

    assign s = ~sync2_q[g];

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        press_q <= press_d;
      end
    end

    always_comb begin
      // NOTE: defaults first so every path assigns every output; no latches.
      state_d = state_q;
      cnt_d   = cnt_q;
      press_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s) begin
            state_d = ST_DEB_PRESS;
            cnt_d   = '0;
          end
        end
        ST_DEB_PRESS: begin
          if (!s) begin
            state_d = ST_IDLE;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (!s) begin
            state_d = ST_DEB_RELEASE;
            cnt_d   = '0;
          end else if (REPEAT_MASK[g] && (cnt_q == DELAY_LAST)) begin
            state_d = ST_REPEAT;
            cnt_d   = '0;
            press_d = 1'b1;
          end else if (cnt_q != '1) begin
            // Saturate so non-repeating keys can be held indefinitely.
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (!s) begin
            state_d = ST_DEB_RELEASE;
            cnt_d   = '0;
          end else if (cnt_q == RATE_LAST) begin
            cnt_d   = '0;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DEB_RELEASE: begin
          if (s) begin
            cnt_d = '0;
          end else if (cnt_q == DEB_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    assign o_press[g] = press_q;
    assign o_held[g]  = (state_q == ST_HELD) || (state_q == ST_REPEAT);
  end

endmodule

// File: doc/key_event_gen.md
# key_event_gen

Converts the raw, active-low, bouncing DE2 push-buttons into the clean single-cycle command pulses the menu controller consumes (select, back, up, down). It sits between the board KEY pins and the top-level menu FSM on the BCLK clock domain. It owns synchronization, debounce, press-edge detection and auto-repeat for navigation keys, so the menu FSM sees at most one pulse per intended step.

## Interface
- NKEY, 4, number of keys; bit map 0=down, 1=up, 2=back, 3=select
- DEBOUNCE_CYC, 20000, cycles a level must be stable before it is accepted (≥2)
- REPEAT_DELAY_CYC, 600000, cycles from the accepted press to the first auto-repeat pulse (≥2)
- REPEAT_RATE_CYC, 150000, cycles between subsequent auto-repeat pulses (≥2)
- REPEAT_MASK, 4'b0011, per-key auto-repeat enable (up/down only)

- i_clk  in  1  BCLK; all logic on its rising edge
- i_rst_n  in  1  synchronous, active-low reset
- i_key_n  in  NKEY  raw KEY pins, 0 = pressed, asynchronous
- o_press  out  NKEY  one-cycle pulse per accepted press or auto-repeat step
- o_held  out  NKEY  level: key is debounced-pressed (HELD or REPEAT)

## Operation
- Per key: 2-flop synchronizer on i_key_n, inverted to pressed level s. Single shared-width counter per key, width $clog2 of the largest of the three cycle parameters.
- Per-key FSM, fully independent between keys:
  - IDLE: s=1 → DEB_PRESS, cnt=0.
  - DEB_PRESS: s=0 → IDLE. Else if cnt==DEBOUNCE_CYC-1 → HELD, cnt=0, o_press=1 for that key. Else cnt+1.
  - HELD: s=0 → DEB_RELEASE, cnt=0. Else if REPEAT_MASK bit set and cnt==REPEAT_DELAY_CYC-1 → REPEAT, cnt=0, pulse. Else cnt+1 (saturates when mask bit clear).
  - REPEAT: s=0 → DEB_RELEASE, cnt=0. Else if cnt==REPEAT_RATE_CYC-1 → cnt=0, pulse. Else cnt+1.
  - DEB_RELEASE: s=1 → cnt=0, stay. Else if cnt==DEBOUNCE_CYC-1 → IDLE. Else cnt+1. Never pulses.
- o_press is registered; never high two consecutive cycles for the same key.
- o_held = state ∈ {HELD, REPEAT}.
- Simultaneous keys: pulses are not arbitrated; several o_press bits may be high in the same cycle. Priority is the consumer's job.
- Reset (i_rst_n=0 at a rising edge) has this effect on the next cycle:
  - Synchronizer flops go to "released" (1).
  - All FSMs go to IDLE, all counters to 0.
  - o_press=0, o_held=0.
  - Reset takes priority over everything else, including mid-debounce and mid-repeat.
- A key still held across reset is treated as a fresh press after reset deasserts.

## Timing
- Raw press first sampled low at edge k, and stable from then on:
  - s=1 after edge k+1.
  - DEB_PRESS entered at edge k+2.
  - o_press high in the cycle after edge k+DEBOUNCE_CYC+2.
- Any return of s to 0 during DEB_PRESS aborts; the next press restarts the full latency.
- First repeat pulse: REPEAT_DELAY_CYC edges after the press pulse. Subsequent repeat pulses: every REPEAT_RATE_CYC edges.
- Release:
  - HELD/REPEAT exits on the edge at which s=0; no pulse is lost or added.
  - IDLE is reached DEBOUNCE_CYC edges after the last s=1 sample.
- Throughput: each key emits at most one pulse per REPEAT_RATE_CYC cycles while held, and exactly one per clean press/release cycle.

## Test plan
Parameters for all tests: DEBOUNCE_CYC=4, REPEAT_DELAY_CYC=10, REPEAT_RATE_CYC=5. Raw change is at edge k.
- Clean select press: i_key_n[3]=0 held for 30 cycles.
  - Exactly one o_press[3] pulse, after edge k+6.
  - o_held[3]=1 from edge k+6 until 1 cycle after release is sampled.
  - No further pulses (mask bit clear).
- Bounce reject: i_key_n[1] low for 3 cycles, high for 2, low for 3, then high.
  - No o_press pulse.
  - o_held stays 0.
- Auto-repeat on up, held for 35 cycles:
  - o_press[1] pulses after edges k+6, k+16, k+21, k+26, k+31, k+36 (the last one only if still sampled held).
  - No pulses after the release is seen.
- Release bounce: release up, re-press within 3 cycles, then release stable.
  - No new pulse during DEB_RELEASE.
  - IDLE reached 4 edges after the last pressed sample.
  - A new clean press afterwards yields one pulse at the normal latency.
- Simultaneous: i_key_n[0] and i_key_n[3] go low at the same edge.
  - o_press[0] and o_press[3] pulse in the same cycle (after k+6).
- Reset mid-repeat: up held in REPEAT, then i_rst_n=0 for 1 cycle.
  - o_press=0 and o_held=0 in the next cycle.
  - With up still held, the next pulse appears 7 cycles after reset deasserts (fresh-press latency), followed by the repeat schedule.
